// File: rtl/ln_log2_norm.sv
// ln_log2_norm: pipelined log2 approximation of an unsigned fixed-point sample.
// The result is the leading-one position as a signed integer field plus the
// bits directly below the leading one as a fraction field.
//
// Optional feature macro: LN_LOG2_NORM_ROUND_EN
//   defined   -> fraction rounded to nearest (half up) using the bit below f
//   undefined -> fraction truncated
// Latency is 3 cycles either way.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   in_valid  : input sample present
//   in_ready  : sample accepted this cycle (combinational, depends on out_ready)
//   in_data   : unsigned x, FRAC_W fraction bits
//   in_tag    : sideband returned with the result
//   out_valid : result present
//   out_ready : downstream accepts result
//   out_data  : {e, f}; e signed (DATA_W-FRAC_W bits), f FRAC_W bits
//   out_zero  : sample was zero
//   out_tag   : tag of presented result
module ln_log2_norm #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_zero,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned E_W = DATA_W - FRAC_W;
  localparam int unsigned P_W = $clog2(DATA_W);
`ifdef LN_LOG2_NORM_ROUND_EN
  // Keep one guard bit below the fraction for rounding.
  localparam int unsigned G_W = FRAC_W + 1;
`else
  localparam int unsigned G_W = FRAC_W;
`endif

  // Stage registers
  logic              s1_v;
  logic [DATA_W-1:0] s1_x;
  logic [P_W-1:0]    s1_p;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_v;
  logic [G_W-1:0]    s2_g;
  logic [E_W-1:0]    s2_e;
  logic              s2_z;
  logic [TAG_W-1:0]  s2_tag;

  // Each stage loads when empty or when its content leaves this cycle
  logic s1_ld, s2_ld, s3_ld;

  assign s3_ld    = !out_valid || out_ready;
  assign s2_ld    = !s2_v || s3_ld;
  assign s1_ld    = !s1_v || s2_ld;
  assign in_ready = s1_ld;

  // Leading-one detector: highest set bit wins
  logic [P_W-1:0] lod_p;

  always_comb begin
    lod_p = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (in_data[i]) lod_p = P_W'(i);
    end
  end

  // S1: register sample with its leading-one position
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v   <= 1'b0;
      s1_x   <= '0;
      s1_p   <= '0;
      s1_tag <= '0;
    end else if (s1_ld) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_x   <= in_data;
        s1_p   <= lod_p;
        s1_tag <= in_tag;
      end
    end
  end

  // S2 combinational: normalise so the leading one sits at the MSB, keep the
  // fraction (and guard) bits below it; the leading one itself is dropped.
  logic [P_W-1:0] sh_amt;
  logic [G_W-1:0] g_nx;
  logic [E_W-1:0] e_nx;
  logic           z_nx;

  assign sh_amt = P_W'(DATA_W - 1) - s1_p;
  assign g_nx   = G_W'((s1_x << sh_amt) >> (DATA_W - 1 - G_W));
  assign e_nx   = E_W'(int'(s1_p) - int'(FRAC_W));
  assign z_nx   = ~|s1_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_v   <= 1'b0;
      s2_g   <= '0;
      s2_e   <= '0;
      s2_z   <= 1'b0;
      s2_tag <= '0;
    end else if (s2_ld) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_g   <= g_nx;
        s2_e   <= e_nx;
        s2_z   <= z_nx;
        s2_tag <= s1_tag;
      end
    end
  end

  // S3 combinational: round or truncate, then pack
  logic [FRAC_W-1:0] f_r;
  logic [E_W-1:0]    e_r;
  logic [DATA_W-1:0] data_nx;

`ifdef LN_LOG2_NORM_ROUND_EN
  logic [FRAC_W:0] f_sum;

  // A carry out of the fraction bumps the exponent and leaves f = 0
  assign f_sum = {1'b0, s2_g[G_W-1:1]} + (FRAC_W + 1)'(s2_g[0]);
  assign f_r   = f_sum[FRAC_W-1:0];
  assign e_r   = s2_e + E_W'(f_sum[FRAC_W]);
`else
  assign f_r = s2_g;
  assign e_r = s2_e;
`endif

  // Zero input maps to most negative e with f = 0
  assign data_nx = s2_z ? {1'b1, (DATA_W - 1)'(0)} : {e_r, f_r};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (s3_ld) begin
      out_valid <= s2_v;
      if (s2_v) begin
        out_data <= data_nx;
        out_zero <= s2_z;
        out_tag  <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_ln_log2_norm.sv
// Self-checking bench for ln_log2_norm (DATA_W=16, FRAC_W=8, TAG_W=4).
module tb_ln_log2_norm;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic [3:0]  out_tag;

  ln_log2_norm #(.DATA_W(16), .FRAC_W(8), .TAG_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_zero (out_zero),
    .out_tag  (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [3:0]  tag;
    logic [15:0] d;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        z;
    logic [3:0]  t;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp;
  int          n_bad;
  logic [15:0] cur_d;
  logic        cur_z;
  logic        rand_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: scale x/2^p by 2^9 to get 1.f with one extra bit, then round/truncate
  function automatic void model(input logic [15:0] x, output logic [15:0] d, output logic z);
    int p, e, t, r;
    if (x == 16'h0000) begin
      d = 16'h8000;
      z = 1'b1;
      return;
    end
    p = 0;
    for (int i = 0; i < 16; i++) if (x[i]) p = i;
    e = p - 8;
    t = (int'(x) << 9) >> p;
`ifdef LN_LOG2_NORM_ROUND_EN
    r = (t + 1) >> 1;
`else
    r = t >> 1;
`endif
    if (r == 512) begin
      r = 256;
      e = e + 1;
    end
    d = {8'(e), 8'(r - 256)};
    z = 1'b0;
  endfunction

  // Present one sample and wait (bounded) for its handshake
  task automatic send(input logic [15:0] x, input logic [3:0] tag,
                      input logic [15:0] d, input logic z);
    bit ok;
    ok       = 1'b0;
    in_data  = x;
    in_tag   = tag;
    cur_d    = d;
    cur_z    = z;
    in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  vec_t tbl[11];

  initial begin
    int   lat;
    int   idx;
    int   n_acc;
    bit   acc;
    bit   seen;
    logic [15:0] rx, rd;
    logic        rz;

    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_tag   = '0;
    out_ready = 1'b1;
    rand_rdy = 1'b0;
    cur_d    = '0;
    cur_z    = 1'b0;

    tbl[0]  = '{16'h0100, 4'd1,  16'h0000, 1'b0};
    tbl[1]  = '{16'h0200, 4'd2,  16'h0100, 1'b0};
    tbl[2]  = '{16'h0300, 4'd3,  16'h0180, 1'b0};
    tbl[3]  = '{16'h0180, 4'd4,  16'h0080, 1'b0};
    tbl[4]  = '{16'h0080, 4'd5,  16'hFF00, 1'b0};
    tbl[5]  = '{16'h0001, 4'd6,  16'hF800, 1'b0};
    tbl[6]  = '{16'h0000, 4'd7,  16'h8000, 1'b1};
    tbl[7]  = '{16'h8000, 4'd8,  16'h0700, 1'b0};
    tbl[8]  = '{16'h00FF, 4'd9,  16'hFFFE, 1'b0};
`ifdef LN_LOG2_NORM_ROUND_EN
    tbl[9]  = '{16'h0FFF, 4'd10, 16'h0400, 1'b0};
    tbl[10] = '{16'hFFFF, 4'd11, 16'h0800, 1'b0};
`else
    tbl[9]  = '{16'h0FFF, 4'd10, 16'h03FF, 1'b0};
    tbl[10] = '{16'hFFFF, 4'd11, 16'h07FF, 1'b0};
`endif

    // Scoreboard monitor: pop/compare on output handshake, push on input handshake
    fork
      forever begin
        exp_t ex;
        @(negedge clk);
        if (rst) begin
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              chk("spurious_out", 32'(sb.size()), 32'd1);
            end else begin
              ex = sb.pop_front();
              chk("out_data", 32'(out_data), 32'(ex.d));
              chk("out_zero", 32'(out_zero), 32'(ex.z));
              chk("out_tag", 32'(out_tag), 32'(ex.t));
            end
          end
          if (in_valid && in_ready) sb.push_back('{cur_d, cur_z, in_tag});
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency of a single sample (1.0, tag 3)
    send(16'h0100, 4'd3, 16'h0000, 1'b0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    drain();

    // Back-to-back: results on consecutive cycles
    send(16'h0300, 4'd5, 16'h0180, 1'b0);
    send(16'h0001, 4'd6, 16'hF800, 1'b0);
    for (int c = 0; c < 10 && !out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("b2b_consecutive", 32'(out_valid), 32'd1);
    drain();

    // Vector table, streamed back-to-back
    foreach (tbl[i]) send(tbl[i].x, tbl[i].tag, tbl[i].d, tbl[i].z);
    drain();

    // Backpressure: 3 accepted, 4th stalls, output held
    out_ready = 1'b0;
    idx       = 0;
    n_acc     = 0;
    in_data   = tbl[0].x;
    in_tag    = tbl[0].tag;
    cur_d     = tbl[0].d;
    cur_z     = tbl[0].z;
    in_valid  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) n_acc++;
      if (acc && idx < 3) begin
        idx++;
        in_data = tbl[idx].x;
        in_tag  = tbl[idx].tag;
        cur_d   = tbl[idx].d;
        cur_z   = tbl[idx].z;
      end
    end
    chk("full_accepted", 32'(n_acc), 32'd3);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_hold_data", 32'(out_data), 32'(tbl[0].d));
    repeat (2) @(posedge clk);
    #1;
    chk("full_hold_data2", 32'(out_data), 32'(tbl[0].d));
    chk("full_hold_tag", 32'(out_tag), 32'(tbl[0].tag));
    out_ready = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("full_4th_accepted", 32'(acc), 32'd1);
    drain();

    // Reset with two samples in flight
    send(tbl[1].x, tbl[1].tag, tbl[1].d, tbl[1].z);
    send(tbl[2].x, tbl[2].tag, tbl[2].d, tbl[2].z);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_zero", 32'(out_zero), 32'd0);
    chk("midrst_out_tag", 32'(out_tag), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_after_rst", 32'(seen), 32'd0);

    // Random samples with random backpressure against the reference model
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom_range(0, 65535)) >> $urandom_range(0, 15);
      model(rx, rd, rz);
      send(rx, 4'($urandom_range(0, 15)), rd, rz);
    end
    rand_rdy = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ln_log2_norm.md
LN_LOG2_NORM -- requirements
Module: ln_log2_norm

Interface
REQ-001 SHALL have parameter DATA_W, default 16: input/output word width in bits.
REQ-002 SHALL have parameter FRAC_W, default 8: fractional bits of input and of the output fraction field; legal only if DATA_W >= FRAC_W+2 and -(FRAC_W) >= -2^(DATA_W-FRAC_W-1).
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each sample.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: input sample present.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts sample this cycle.
REQ-008 SHALL have port in_data, input, DATA_W: unsigned fixed-point x, FRAC_W fraction bits.
REQ-009 SHALL have port in_tag, input, TAG_W: sideband, returned unchanged with its sample.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts result.
REQ-012 SHALL have port out_data, output, DATA_W: {e, f}; e = signed two's-complement integer field (DATA_W-FRAC_W bits), f = FRAC_W-bit fraction; value approximates log2(x).
REQ-013 SHALL have port out_zero, output, 1 bit: sample was x = 0.
REQ-014 SHALL have port out_tag, output, TAG_W: tag of the presented result.

Function
REQ-015 SHALL transfer a sample on a cycle where valid and ready are both high, at either port.
REQ-016 SHALL compute p = position of the most significant 1 in x (0..DATA_W-1) with an internal leading-one detector; no one-hot input is needed.
REQ-017 SHALL compute e = p - FRAC_W and f = the FRAC_W bits directly below the leading one, left-aligned, with zeros filled below bit 0.
REQ-018 SHALL implement 3 pipeline stages: S1 leading-one detect and register, S2 barrel shift (x << (DATA_W-1-p)), S3 round/pack to output register.
REQ-019 SHALL present a result with out_valid exactly 3 cycles after its input handshake when out_ready is held high.
REQ-020 SHALL let each stage load when it is empty or its content moves downstream the same cycle; in_ready = S1 can load, combinationally dependent on out_ready; sustained throughput 1 sample/cycle.
REQ-021 SHALL hold out_data, out_zero and out_tag stable while out_valid=1 and out_ready=0.
REQ-022 SHALL accept at most 3 samples without an output handshake; the 4th waits with in_ready=0.
REQ-023 SHALL preserve sample order; no sample is dropped or duplicated.
REQ-024 SHALL, for x = 0, output out_data = {1, 0...0} (most negative e, f = 0) and out_zero = 1; out_zero = 0 otherwise.
REQ-025 SHALL allow a simultaneous input and output handshake on a full pipeline.

Reset
REQ-026 SHALL, on rst low, asynchronously clear all stage valid flags, out_valid=0, out_data=0, out_zero=0, out_tag=0; in_ready=1 once rst is high.
REQ-027 SHALL discard in-flight samples on reset mid-operation; no stale result appears after reset release.

Configuration
REQ-028 SHALL provide macro LN_LOG2_NORM_ROUND_EN.
REQ-029 SHALL, with LN_LOG2_NORM_ROUND_EN defined, round f to nearest using the bit directly below f (half rounds up); a carry out of f sets f=0 and e=e+1.
REQ-030 SHALL, without LN_LOG2_NORM_ROUND_EN, truncate f; latency unchanged either way.

Verification (DATA_W=16, FRAC_W=8, out_ready=1 unless stated)
REQ-031 SHALL cover: in_data 0x0100 (1.0), tag 3 -> 3 cycles later out_data 0x0000, out_zero 0, out_tag 3.
REQ-032 SHALL cover: 0x0300 (3.0) -> 0x0180; 0x0001 -> 0xF800; back-to-back both, results on consecutive cycles.
REQ-033 SHALL cover: 0x0000 -> out_data 0x8000, out_zero 1.
REQ-034 SHALL cover: 0x0FFF -> 0x0400 with ROUND_EN, 0x03FF without.
REQ-035 SHALL cover: out_ready=0, present 4 samples -> 3 accepted, in_ready low, out_data held; out_ready=1 -> 4 results in order with correct tags.
REQ-036 SHALL cover: rst asserted with 2 samples in flight -> all outputs zero immediately, no out_valid after release until new input.
